// File: rtl/joker_cmd_engine_if.sv
// EP2 OUT / EP1 IN buffer bus between the USB endpoint buffers and joker_cmd_engine.
// master = command engine side, slave = endpoint buffer side.
interface joker_cmd_engine_if;
  logic        buf_out_hasdata;
  logic [9:0]  buf_out_len;
  logic [7:0]  buf_out_q;
  logic [10:0] buf_out_addr;
  logic        buf_out_arm;
  logic        buf_out_arm_ack;
  logic        usb_in_ready;
  logic [10:0] usb_in_addr;
  logic [7:0]  usb_in_data;
  logic        usb_in_wren;
  logic [10:0] usb_in_commit_len;
  logic        usb_in_commit;
  logic        usb_in_commit_ack;

  // Handshakes: commit and arm are level requests held high until the peer's ack
  // shows a falling edge; wren writes one byte per cycle only while usb_in_ready=1.
  modport master (
    input  buf_out_hasdata, buf_out_len, buf_out_q, buf_out_arm_ack,
    input  usb_in_ready, usb_in_commit_ack,
    output buf_out_addr, buf_out_arm,
    output usb_in_addr, usb_in_data, usb_in_wren, usb_in_commit_len, usb_in_commit
  );
  modport slave (
    output buf_out_hasdata, buf_out_len, buf_out_q, buf_out_arm_ack,
    output usb_in_ready, usb_in_commit_ack,
    input  buf_out_addr, buf_out_arm,
    input  usb_in_addr, usb_in_data, usb_in_wren, usb_in_commit_len, usb_in_commit
  );
endinterface

// File: rtl/joker_cmd_engine.sv
// Joker TV jcmd engine: fetches one EP2 OUT packet, runs it against a control register
// bank, replies through EP1 IN, re-arms EP2 OUT. Optional watchdog: JOKER_CMD_TIMEOUT_EN.
module joker_cmd_engine #(
  parameter int                    NUM_REGS    = 16,
  parameter int                    RD_LAT      = 3,
  parameter int                    MAX_RD      = 64,
  parameter logic [15:0]           FW_VERSION  = 16'h0200,
  parameter logic [NUM_REGS*8-1:0] REG_RST     = '0,
  parameter int                    TIMEOUT_CYC = 5000000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  joker_cmd_engine_if.master      bus,
  output logic [NUM_REGS*8-1:0]   regs_out,
  output logic [NUM_REGS-1:0]     regs_wr_strobe,
  output logic                    err_timeout,
  output logic [3:0]              dbg_state
);
  localparam int          LW    = $clog2(RD_LAT + 1);
  localparam int          RIW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [11:0] NREG  = 12'(NUM_REGS);
  localparam logic [10:0] MAXRD = 11'(MAX_RD);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH_OP, S_FETCH_IDX, S_DISPATCH, S_FETCH_CNT, S_WR_BYTE,
    S_WAIT_READY, S_EMIT, S_COMMIT, S_WAIT_CACK, S_ARM, S_WAIT_AACK
  } state_e;

  state_e        state_q, state_d;
  logic [10:0]   addr_q, addr_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [9:0]    len_q, len_d;
  logic [7:0]    op_q, op_d, idx_q, idx_d, status_q, status_d;
  logic [10:0]   ptr_q, ptr_d, byte_cnt_q, byte_cnt_d, commit_len_q, commit_len_d;
  logic          commit_q, commit_d, arm_q, arm_d, cack_prev_q, aack_prev_q;
  logic [7:0]    regs_q [NUM_REGS];
  logic [7:0]    regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] strobe_q, strobe_d;

  logic          lat_done, tmo_hit, wren;
  logic [10:0]   cnt_ext, rd_n;
  logic [11:0]   rd_end, widx, ridx;
  logic [7:0]    reply_byte;

  // A fetched byte is trusted only once RD_LAT full cycles have passed since addr_q moved.
  assign lat_done = (lat_q == LW'(RD_LAT));
  assign wren     = (state_q == S_EMIT);
  assign cnt_ext  = {3'b000, bus.buf_out_q};
  assign rd_n     = (cnt_ext > MAXRD) ? MAXRD : cnt_ext;
  assign rd_end   = {4'b0000, idx_q} + {1'b0, rd_n};
  assign widx     = {4'b0000, idx_q} + {1'b0, ptr_q} - 12'd2;
  assign ridx     = {4'b0000, idx_q} + {1'b0, byte_cnt_q} - 12'd2;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    lat_d        = lat_done ? lat_q : lat_q + 1'b1;
    len_d        = len_q;
    op_d         = op_q;
    idx_d        = idx_q;
    status_d     = status_q;
    ptr_d        = ptr_q;
    byte_cnt_d   = byte_cnt_q;
    commit_len_d = commit_len_q;
    commit_d     = commit_q;
    arm_d        = arm_q;
    regs_d       = regs_q;
    strobe_d     = '0;
    case (state_q)
      S_IDLE: if (bus.buf_out_hasdata) begin
        len_d   = bus.buf_out_len;
        addr_d  = 11'd0;
        lat_d   = '0;
        state_d = S_FETCH_OP;
      end
      S_FETCH_OP: if (lat_done) begin
        op_d    = bus.buf_out_q;
        addr_d  = 11'd1;
        lat_d   = '0;
        state_d = S_FETCH_IDX;
      end
      S_FETCH_IDX: if (lat_done) begin
        idx_d   = bus.buf_out_q;
        state_d = S_DISPATCH;
      end
      S_DISPATCH: begin
        ptr_d  = 11'd2;
        addr_d = 11'd2;
        lat_d  = '0;
        case (op_q)
          8'h00: begin commit_len_d = 11'd3; state_d = S_WAIT_READY; end
          8'h20: state_d = (len_q >= 10'd3) ? S_WR_BYTE : S_ARM;
          8'h21: begin
            if (len_q >= 10'd3) state_d = S_FETCH_CNT;
            else begin
              status_d     = 8'h04;
              commit_len_d = 11'd2;
              state_d      = S_WAIT_READY;
            end
          end
          default: begin commit_len_d = 11'd2; state_d = S_WAIT_READY; end
        endcase
      end
      S_FETCH_CNT: if (lat_done) begin
        status_d     = {6'd0, cnt_ext > MAXRD, (rd_n != 11'd0) && (rd_end > NREG)};
        commit_len_d = rd_n + 11'd2;
        state_d      = S_WAIT_READY;
      end
      S_WR_BYTE: begin
        if (ptr_q >= {1'b0, len_q}) state_d = S_ARM;
        else if (lat_done) begin
          // Bytes that land past the last register are consumed but discarded.
          if (widx < NREG) begin
            regs_d[widx[RIW-1:0]]   = bus.buf_out_q;
            strobe_d[widx[RIW-1:0]] = 1'b1;
          end
          ptr_d  = ptr_q + 11'd1;
          addr_d = ptr_q + 11'd1;
          lat_d  = '0;
        end
      end
      S_WAIT_READY: begin
        byte_cnt_d = 11'd0;
        if (bus.usb_in_ready) state_d = S_EMIT;
        else if (tmo_hit)     state_d = S_ARM;
      end
      S_EMIT: begin
        byte_cnt_d = byte_cnt_q + 11'd1;
        if (byte_cnt_q == commit_len_q - 11'd1) begin
          commit_d = 1'b1;
          state_d  = S_COMMIT;
        end
      end
      S_COMMIT: state_d = S_WAIT_CACK;
      S_WAIT_CACK: if ((cack_prev_q && !bus.usb_in_commit_ack) || tmo_hit) begin
        commit_d = 1'b0;
        state_d  = S_ARM;
      end
      S_ARM: begin
        arm_d   = 1'b1;
        state_d = S_WAIT_AACK;
      end
      S_WAIT_AACK: if ((aack_prev_q && !bus.buf_out_arm_ack) || tmo_hit) begin
        arm_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    reply_byte = 8'h00;
    case (op_q)
      8'h00: reply_byte = (byte_cnt_q == 11'd0) ? 8'h00 :
                          (byte_cnt_q == 11'd1) ? FW_VERSION[15:8] : FW_VERSION[7:0];
      8'h21: begin
        if (byte_cnt_q == 11'd0)      reply_byte = 8'h21;
        else if (byte_cnt_q == 11'd1) reply_byte = status_q;
        else if (ridx < NREG)         reply_byte = regs_q[ridx[RIW-1:0]];
      end
      default: reply_byte = (byte_cnt_q == 11'd0) ? 8'hFF : op_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      lat_q        <= '0;
      len_q        <= '0;
      op_q         <= '0;
      idx_q        <= '0;
      status_q     <= '0;
      ptr_q        <= '0;
      byte_cnt_q   <= '0;
      commit_len_q <= '0;
      commit_q     <= 1'b0;
      arm_q        <= 1'b0;
      cack_prev_q  <= 1'b0;
      aack_prev_q  <= 1'b0;
      strobe_q     <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= REG_RST[8*i +: 8];
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      lat_q        <= lat_d;
      len_q        <= len_d;
      op_q         <= op_d;
      idx_q        <= idx_d;
      status_q     <= status_d;
      ptr_q        <= ptr_d;
      byte_cnt_q   <= byte_cnt_d;
      commit_len_q <= commit_len_d;
      commit_q     <= commit_d;
      arm_q        <= arm_d;
      cack_prev_q  <= bus.usb_in_commit_ack;
      aack_prev_q  <= bus.buf_out_arm_ack;
      strobe_q     <= strobe_d;
      regs_q       <= regs_d;
    end
  end

`ifdef JOKER_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          err_q, in_wait;

  assign in_wait = (state_q == S_WAIT_READY) || (state_q == S_WAIT_CACK) || (state_q == S_WAIT_AACK);
  assign tmo_hit = in_wait && (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));

  // Counter restarts on every state change so each wait gets its own budget.
  always_comb begin
    tmo_cnt_d = '0;
    if (in_wait && (state_d == state_q)) tmo_cnt_d = tmo_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_q | tmo_hit;
    end
  end
  assign err_timeout = err_q;
`else
  assign tmo_hit     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
    assign regs_out[8*g +: 8] = regs_q[g];
  end

  assign regs_wr_strobe        = strobe_q;
  assign dbg_state             = state_q;
  assign bus.buf_out_addr      = addr_q;
  assign bus.buf_out_arm       = arm_q;
  assign bus.usb_in_wren       = wren;
  assign bus.usb_in_addr       = wren ? byte_cnt_q : 11'd0;
  assign bus.usb_in_data       = wren ? reply_byte : 8'h00;
  assign bus.usb_in_commit_len = commit_len_q;
  assign bus.usb_in_commit     = commit_q;
endmodule

// File: tb/tb_joker_cmd_engine.sv
// Bench for joker_cmd_engine: directed jcmd packets plus randomized commands checked
// against a packet-level reference model of the register bank and reply format.
module tb_joker_cmd_engine;
  localparam int           NUM_REGS = 16;
  localparam int           RD_LAT   = 3;
  localparam int           MAX_RD   = 64;
  localparam logic [15:0]  FW       = 16'h0200;
  localparam logic [127:0] REG_RST_TB = 128'h0000_0000_0000_0000_0000_0000_0000_C35A;
  localparam int           TMO      = 1000;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  joker_cmd_engine_if bus_if ();
  logic [127:0] regs_out;
  logic [15:0]  regs_wr_strobe;
  logic         err_timeout;
  logic [3:0]   dbg_state;

  joker_cmd_engine #(
    .NUM_REGS(NUM_REGS), .RD_LAT(RD_LAT), .MAX_RD(MAX_RD), .FW_VERSION(FW),
    .REG_RST(REG_RST_TB), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus_if.master),
    .regs_out(regs_out), .regs_wr_strobe(regs_wr_strobe),
    .err_timeout(err_timeout), .dbg_state(dbg_state)
  );

  // EP2 OUT buffer: read data follows the address after exactly RD_LAT clocks.
  logic [7:0]  pkt [0:2047];
  logic [10:0] addr_pipe [RD_LAT];
  always @(posedge clk) begin
    addr_pipe[0] <= bus_if.buf_out_addr;
    for (int i = 1; i < RD_LAT; i++) addr_pipe[i] <= addr_pipe[i-1];
  end
  assign bus_if.buf_out_q = pkt[addr_pipe[RD_LAT-1]];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // EP1 IN / strobe monitor, sampled on the falling clock edge.
  logic [7:0]  wr_log [$];
  int          addr_err = 0, early_wr = 0, commit_rises = 0, strb_total = 0;
  logic [10:0] commit_len_seen = '0, last_addr = '0;
  logic        gap_ok = 1'b0, prev_wren = 1'b0, prev_commit = 1'b0;
  logic [15:0] strb_mask = '0;
  always @(negedge clk) begin
    if (bus_if.usb_in_wren) begin
      wr_log.push_back(bus_if.usb_in_data);
      if (bus_if.usb_in_addr !== (prev_wren ? last_addr + 11'd1 : 11'd0)) addr_err <= addr_err + 1;
      if (!bus_if.usb_in_ready) early_wr <= early_wr + 1;
      last_addr <= bus_if.usb_in_addr;
    end
    if (bus_if.usb_in_commit && !prev_commit) begin
      commit_rises    <= commit_rises + 1;
      commit_len_seen <= bus_if.usb_in_commit_len;
      gap_ok          <= prev_wren;
    end
    strb_total  <= strb_total + $countones(regs_wr_strobe);
    strb_mask   <= strb_mask | regs_wr_strobe;
    prev_wren   <= bus_if.usb_in_wren;
    prev_commit <= bus_if.usb_in_commit;
  end

  // Ack responders: raise ack after a random delay, hold, then drop (falling edge = done).
  logic cack_en = 1'b1;
  initial begin
    bus_if.usb_in_commit_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_if.usb_in_commit && cack_en) begin
        repeat ($urandom_range(1, 4)) @(negedge clk);
        bus_if.usb_in_commit_ack = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        bus_if.usb_in_commit_ack = 1'b0;
        repeat (2) @(negedge clk);
      end
    end
  end
  initial begin
    bus_if.buf_out_arm_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_if.buf_out_arm) begin
        repeat ($urandom_range(1, 4)) @(negedge clk);
        bus_if.buf_out_arm_ack = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        bus_if.buf_out_arm_ack = 1'b0;
        repeat (2) @(negedge clk);
      end
    end
  end

  // Reference model of the register bank.
  logic [7:0] regs_m [NUM_REGS];
  function automatic logic [127:0] pack_m();
    logic [127:0] v = '0;
    for (int i = 0; i < NUM_REGS; i++) v[8*i +: 8] = regs_m[i];
    return v;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) regs_m[i] = REG_RST_TB[8*i +: 8];
  endtask

  task automatic run_cmd(input string tag, input int len, input int ready_delay);
    logic [7:0]  exp_q [$];
    logic [7:0]  op, idx, st;
    logic [15:0] exp_mask;
    int          n, exp_strb, base_wr, base_cr, base_ae, base_ew, base_st, cyc;
    op = pkt[0]; idx = pkt[1]; exp_mask = '0; exp_strb = 0;
    case (op)
      8'h00: exp_q = '{8'h00, FW[15:8], FW[7:0]};
      8'h20: for (int k = 2; k < len; k++)
               if (int'(idx) + k - 2 < NUM_REGS) begin
                 regs_m[int'(idx) + k - 2] = pkt[k];
                 exp_mask[int'(idx) + k - 2] = 1'b1;
                 exp_strb++;
               end
      8'h21: begin
        if (len < 3) exp_q = '{8'h21, 8'h04};
        else begin
          n  = (int'(pkt[2]) > MAX_RD) ? MAX_RD : int'(pkt[2]);
          st = (int'(pkt[2]) > MAX_RD) ? 8'h02 : 8'h00;
          exp_q = '{8'h21, 8'h00};
          for (int i = 0; i < n; i++) begin
            if (int'(idx) + i < NUM_REGS) exp_q.push_back(regs_m[int'(idx) + i]);
            else begin exp_q.push_back(8'h00); st[0] = 1'b1; end
          end
          exp_q[1] = st;
        end
      end
      default: exp_q = '{8'hFF, op};
    endcase
    base_wr = wr_log.size(); base_cr = commit_rises; base_ae = addr_err;
    base_ew = early_wr; base_st = strb_total;
    @(negedge clk);
    strb_mask = '0;
    bus_if.buf_out_len = 10'(len);
    bus_if.buf_out_hasdata = 1'b1;
    if (ready_delay > 0) bus_if.usb_in_ready = 1'b0;
    cyc = 0;
    while (!bus_if.buf_out_arm && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      if (ready_delay > 0 && cyc == ready_delay) begin
        check_eq({tag, ":no_wr_before_ready"}, 128'(wr_log.size() - base_wr), 128'(0));
        bus_if.usb_in_ready = 1'b1;
      end
    end
    check_eq({tag, ":arm_raised"}, 128'(bus_if.buf_out_arm), 128'(1));
    bus_if.buf_out_hasdata = 1'b0;
    bus_if.usb_in_ready = 1'b1;
    cyc = 0;
    while ((bus_if.buf_out_arm || dbg_state != 4'd0) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, ":back_idle"}, 128'(bus_if.buf_out_arm || dbg_state != 4'd0), 128'(0));
    repeat (2) @(negedge clk);
    check_eq({tag, ":reply_len"}, 128'(wr_log.size() - base_wr), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && base_wr + i < wr_log.size(); i++)
      check_eq($sformatf("%s:byte%0d", tag, i), 128'(wr_log[base_wr + i]), 128'(exp_q[i]));
    check_eq({tag, ":commits"}, 128'(commit_rises - base_cr), 128'(exp_q.size() > 0 ? 1 : 0));
    if (exp_q.size() > 0) begin
      check_eq({tag, ":commit_len"}, 128'(commit_len_seen), 128'(exp_q.size()));
      check_eq({tag, ":commit_after_wr"}, 128'(gap_ok), 128'(1));
    end
    check_eq({tag, ":wr_addr_seq"}, 128'(addr_err - base_ae), 128'(0));
    check_eq({tag, ":wr_when_busy"}, 128'(early_wr - base_ew), 128'(0));
    check_eq({tag, ":strobe_cnt"}, 128'(strb_total - base_st), 128'(exp_strb));
    check_eq({tag, ":strobe_mask"}, 128'(strb_mask), 128'(exp_mask));
    check_eq({tag, ":regs"}, regs_out, pack_m());
  endtask

  initial begin
    int          b, len, cyc, sel;
    logic [7:0]  exp5 [5];
    logic [7:0]  op;
    for (int i = 0; i < 2048; i++) pkt[i] = 8'h00;
    reset_n = 1'b0;
    bus_if.buf_out_hasdata = 1'b0;
    bus_if.buf_out_len = '0;
    bus_if.usb_in_ready = 1'b1;
    model_reset();
    repeat (5) @(negedge clk);
    check_eq("rst_regs", regs_out, REG_RST_TB);
    check_eq("rst_handshakes", {bus_if.buf_out_arm, bus_if.usb_in_commit, bus_if.usb_in_wren,
             err_timeout, regs_wr_strobe}, '0);
    check_eq("rst_out_bus", {bus_if.buf_out_addr, bus_if.usb_in_addr, bus_if.usb_in_data,
             bus_if.usb_in_commit_len}, '0);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("idle_no_data", 128'(dbg_state), 128'(0));
    check_eq("idle_no_arm", 128'(bus_if.buf_out_arm), 128'(0));

    pkt[0] = 8'h20; pkt[1] = 8'h02; pkt[2] = 8'hAA; pkt[3] = 8'hBB;
    run_cmd("wr_2", 4, 0);
    check_eq("wr_2_reg2", regs_out[23:16], 128'hAA);
    check_eq("wr_2_reg3", regs_out[31:24], 128'hBB);

    pkt[0] = 8'h20; pkt[1] = 8'h0F; pkt[2] = 8'h11; pkt[3] = 8'h22;
    run_cmd("wr_edge", 4, 0);
    pkt[0] = 8'h21; pkt[1] = 8'h0E; pkt[2] = 8'h03;
    b = wr_log.size();
    run_cmd("rd_edge", 3, 0);
    exp5 = '{8'h21, 8'h01, 8'h00, 8'h11, 8'h00};
    for (int i = 0; i < 5; i++)
      if (b + i < wr_log.size()) check_eq($sformatf("rd_edge_const%0d", i), 128'(wr_log[b + i]), 128'(exp5[i]));

    pkt[0] = 8'h00; pkt[1] = 8'h00;
    run_cmd("version_wait", 2, 100);

    pkt[0] = 8'h7E;
    run_cmd("unknown", 1, 0);

    pkt[0] = 8'h21; pkt[1] = 8'h00; pkt[2] = 8'd200;
    run_cmd("rd_clip", 3, 0);
    pkt[0] = 8'h21; pkt[1] = 8'h03;
    run_cmd("rd_short", 2, 0);
    pkt[0] = 8'h20; pkt[1] = 8'h05;
    run_cmd("wr_short", 2, 0);

    // Reset in the middle of a long write must abort and restore reset values.
    pkt[0] = 8'h20; pkt[1] = 8'h00;
    for (int i = 2; i < 42; i++) pkt[i] = 8'($urandom_range(0, 255));
    @(negedge clk);
    bus_if.buf_out_len = 10'd42;
    bus_if.buf_out_hasdata = 1'b1;
    repeat (30) @(negedge clk);
    reset_n = 1'b0;
    bus_if.buf_out_hasdata = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_regs", regs_out, REG_RST_TB);
    check_eq("mid_rst_state", 128'({dbg_state, bus_if.buf_out_arm, bus_if.usb_in_commit}), 128'(0));
    reset_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    pkt[0] = 8'h21; pkt[1] = 8'h00; pkt[2] = 8'h04;
    run_cmd("rd_after_rst", 3, 0);

    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 3);
      for (int i = 0; i < 16; i++) pkt[i] = 8'($urandom_range(0, 255));
      pkt[1] = 8'($urandom_range(0, 20));
      case (sel)
        0: begin pkt[0] = 8'h00; len = $urandom_range(1, 4); end
        1: begin pkt[0] = 8'h20; len = $urandom_range(1, 12); end
        2: begin
          pkt[0] = 8'h21; len = $urandom_range(1, 4);
          pkt[2] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(65, 255)) : 8'($urandom_range(0, 24));
        end
        default: begin
          op = 8'h20;
          while (op == 8'h00 || op == 8'h20 || op == 8'h21) op = 8'($urandom_range(1, 255));
          pkt[0] = op; len = $urandom_range(1, 4);
        end
      endcase
      run_cmd($sformatf("rnd%0d", t), len, $urandom_range(0, 8));
    end

`ifdef JOKER_CMD_TIMEOUT_EN
    cack_en = 1'b0;
    pkt[0] = 8'h00;
    @(negedge clk);
    bus_if.buf_out_len = 10'd1;
    bus_if.buf_out_hasdata = 1'b1;
    cyc = 0;
    while (!bus_if.usb_in_commit && cyc < 200) begin @(negedge clk); cyc++; end
    check_eq("tmo_commit_seen", 128'(bus_if.usb_in_commit), 128'(1));
    cyc = 0;
    while (!err_timeout && cyc < 3000) begin @(negedge clk); cyc++; end
    check_eq("tmo_flag", 128'(err_timeout), 128'(1));
    check_eq("tmo_cycles", 128'(cyc >= TMO - 5 && cyc <= TMO + 5), 128'(1));
    check_eq("tmo_commit_dropped", 128'(bus_if.usb_in_commit), 128'(0));
    cyc = 0;
    while (!bus_if.buf_out_arm && cyc < 50) begin @(negedge clk); cyc++; end
    check_eq("tmo_arm", 128'(bus_if.buf_out_arm), 128'(1));
    bus_if.buf_out_hasdata = 1'b0;
    cyc = 0;
    while ((bus_if.buf_out_arm || dbg_state != 4'd0) && cyc < 100) begin @(negedge clk); cyc++; end
    check_eq("tmo_idle", 128'(dbg_state), 128'(0));
    check_eq("tmo_sticky", 128'(err_timeout), 128'(1));
    cack_en = 1'b1;
`else
    check_eq("no_timeout_flag", 128'(err_timeout), 128'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
